// File: rtl/cmp_rr_arbiter.sv
// cmp_rr_arbiter
// Two requesters share one 3-bit relation classifier under round-robin
// arbitration. The winning (A, B) pair is classified and stored, with its
// requester id, in a single-entry output register that drains over
// valid/ready.
// Optional build macro: CMP_ARB_STATS_EN adds saturating per-requester
// accept counters cnt0/cnt1 of width CNT_W.
module cmp_rr_arbiter
`ifdef CMP_ARB_STATS_EN
#(
    parameter int CNT_W = 8
)
`endif
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [2:0]       req0_a,
    input  logic [2:0]       req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [2:0]       req1_a,
    input  logic [2:0]       req1_b,
    output logic             req1_ready,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_id,
    output logic [4:0]       res_flags
`ifdef CMP_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
`endif
);

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    logic [0:0] state;
    logic       last_grant;
    logic       grant_valid;
    logic       grant_id;
    logic       can_accept;
    logic       accept;
    logic [4:0] flags0;
    logic [4:0] flags1;

    // Flags are {gray, excess_3, more, less, no_relation}. The difference is
    // taken larger-minus-smaller so it never wraps inside 3 bits.
    function automatic logic [4:0] classify(input logic [2:0] a, input logic [2:0] b);
        logic [2:0] x;
        logic [2:0] diff;
        logic       gray;
        logic       ex3;
        logic       more;
        logic       less;
        x    = a ^ b;
        gray = (x == 3'b001) || (x == 3'b010) || (x == 3'b100);
        more = (a > b);
        less = (a < b);
        diff = more ? (a - b) : (b - a);
        ex3  = (diff == 3'd3);
        return {gray, ex3, more, less, ~(gray | ex3 | more | less)};
    endfunction

    // Pick a winner from the valids and the previous winner only; the
    // readies never feed back into the choice.
    always_comb begin
        grant_valid = req0_valid | req1_valid;
        grant_id    = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_id = ~last_grant;
        end else if (req1_valid) begin
            grant_id = 1'b1;
        end
    end

    // The output register can take a new result when empty or when its
    // current one leaves this cycle; reset blocks any handshake.
    always_comb begin
        can_accept = rst_n && ((state == EMPTY) || res_ready);
        accept     = can_accept && grant_valid;
        req0_ready = accept && !grant_id;
        req1_ready = accept && grant_id;
        flags0     = classify(req0_a, req0_b);
        flags1     = classify(req1_a, req1_b);
    end

    assign res_valid = (state == FULL);

    // Output stage: load on accept, empty on a drain with no new accept,
    // hold contents while the consumer stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= EMPTY;
            last_grant <= 1'b1;
            res_id     <= 1'b0;
            res_flags  <= 5'd0;
        end else if (accept) begin
            state      <= FULL;
            last_grant <= grant_id;
            res_id     <= grant_id;
            res_flags  <= grant_id ? flags1 : flags0;
        end else if ((state == FULL) && res_ready) begin
            state      <= EMPTY;
        end
    end

`ifdef CMP_ARB_STATS_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Per-requester accept counters that stick at their maximum value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (req0_ready && (cnt0 != CNT_MAX)) begin
                cnt0 <= cnt0 + CNT_ONE;
            end
            if (req1_ready && (cnt1 != CNT_MAX)) begin
                cnt1 <= cnt1 + CNT_ONE;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cmp_rr_arbiter.sv
// tb_cmp_rr_arbiter
// Scoreboard bench for cmp_rr_arbiter. A reference model decides each cycle
// which pair is taken and queues its expected result; an independent monitor
// pops and compares whenever the DUT hands a result to the consumer.
// Honours CMP_ARB_STATS_EN (instantiated with CNT_W=2).
module tb_cmp_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0_valid = 1'b0;
    logic [2:0] req0_a = 3'd0;
    logic [2:0] req0_b = 3'd0;
    logic       req0_ready;
    logic       req1_valid = 1'b0;
    logic [2:0] req1_a = 3'd0;
    logic [2:0] req1_b = 3'd0;
    logic       req1_ready;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic       res_id;
    logic [4:0] res_flags;

    int compared = 0;
    int mismatched = 0;

    // Expected results, oldest first: {id, flags}
    logic [5:0] sb[$];

    // Model state
    bit m_full = 1'b0;
    int m_last = 1;
    int m_cnt0 = 0;
    int m_cnt1 = 0;

`ifdef CMP_ARB_STATS_EN
    localparam int CNT_W_TB = 2;
    logic [CNT_W_TB-1:0] cnt0;
    logic [CNT_W_TB-1:0] cnt1;

    cmp_rr_arbiter #(.CNT_W(CNT_W_TB)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id), .res_flags(res_flags),
        .cnt0(cnt0), .cnt1(cnt1)
    );
`else
    cmp_rr_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id), .res_flags(res_flags)
    );
`endif

    always #5 clk = ~clk;

    // Relation flags from plain integer arithmetic
    function automatic logic [4:0] modelFlags(input logic [2:0] a, input logic [2:0] b);
        int ia;
        int ib;
        int d;
        bit gray;
        bit ex3;
        bit more;
        bit less;
        ia   = int'(a);
        ib   = int'(b);
        d    = ia - ib;
        gray = ($countones(a ^ b) == 1);
        ex3  = (d == 3) || (d == -3);
        more = (ia > ib);
        less = (ia < ib);
        return {gray, ex3, more, less, (ia == ib)};
    endfunction

    task automatic compareVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle's inputs shortly after the rising edge
    task automatic applyStimulus(input bit v0, input logic [2:0] a0, input logic [2:0] b0,
                                 input bit v1, input logic [2:0] a1, input logic [2:0] b1,
                                 input bit rr, input bit rs);
        @(posedge clk);
        #1;
        req0_valid = v0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_a = a1; req1_b = b1;
        res_ready  = rr;
        rst_n      = rs;
    endtask

    // At the falling edge: check handshake outputs against the model, then
    // advance the model to what the next rising edge should produce
    task automatic checkOutput(output bit acc0, output bit acc1);
        int  win;
        bit  acc;
        int  lim;
        win = -1;
        if (rst_n) begin
            if (req0_valid && req1_valid) win = (m_last == 0) ? 1 : 0;
            else if (req0_valid)          win = 0;
            else if (req1_valid)          win = 1;
        end
        acc  = (win >= 0) && (!m_full || res_ready);
        acc0 = acc && (win == 0);
        acc1 = acc && (win == 1);
        compareVal("req0_ready", {31'd0, req0_ready}, {31'd0, acc0});
        compareVal("req1_ready", {31'd0, req1_ready}, {31'd0, acc1});
        compareVal("res_valid",  {31'd0, res_valid},  {31'd0, m_full});
`ifdef CMP_ARB_STATS_EN
        compareVal("cnt0", {{(32-CNT_W_TB){1'b0}}, cnt0}, m_cnt0);
        compareVal("cnt1", {{(32-CNT_W_TB){1'b0}}, cnt1}, m_cnt1);
        lim = (1 << CNT_W_TB) - 1;
`else
        lim = 255;
`endif
        if (!rst_n) begin
            m_full = 1'b0;
            m_last = 1;
            m_cnt0 = 0;
            m_cnt1 = 0;
            sb.delete();
        end else begin
            if (acc0) begin
                sb.push_back({1'b0, modelFlags(req0_a, req0_b)});
                if (m_cnt0 < lim) m_cnt0++;
            end
            if (acc1) begin
                sb.push_back({1'b1, modelFlags(req1_a, req1_b)});
                if (m_cnt1 < lim) m_cnt1++;
            end
            if (acc) begin
                m_full = 1'b1;
                m_last = win;
            end else if (res_ready) begin
                m_full = 1'b0;
            end
        end
    endtask

    task automatic runCycle(input bit v0, input logic [2:0] a0, input logic [2:0] b0,
                            input bit v1, input logic [2:0] a1, input logic [2:0] b1,
                            input bit rr, input bit rs, output bit acc0, output bit acc1);
        applyStimulus(v0, a0, b0, v1, a1, b1, rr, rs);
        @(negedge clk);
        checkOutput(acc0, acc1);
    endtask

    // Monitor: compare whatever result the DUT is presenting with the oldest
    // expected entry; retire it when the consumer takes it
    always @(negedge clk) begin
        logic [5:0] exp;
        if (rst_n === 1'b1 && res_valid === 1'b1) begin
            if (sb.size() == 0) begin
                compareVal("unexpected_result", {31'd0, res_valid}, 32'd0);
            end else begin
                exp = sb[0];
                compareVal("res_id",    {31'd0, res_id},    {31'd0, exp[5]});
                compareVal("res_flags", {27'd0, res_flags}, {27'd0, exp[4:0]});
                if (res_ready) void'(sb.pop_front());
            end
        end
    end

    initial begin
        bit a0;
        bit a1;
        bit p0v;
        bit p1v;
        logic [2:0] p0a;
        logic [2:0] p0b;
        logic [2:0] p1a;
        logic [2:0] p1b;
        bit rr;
        bit rs;

        // Reset held two cycles with both requesters valid
        runCycle(1, 3'd4, 3'd1, 1, 3'd7, 3'd7, 1, 0, a0, a1);
        runCycle(1, 3'd4, 3'd1, 1, 3'd7, 3'd7, 1, 0, a0, a1);
        compareVal("reset_flags", {27'd0, res_flags}, 32'd0);

        // Contention: alternating winners, requester 0 first
        for (int i = 0; i < 4; i++) runCycle(1, 3'd4, 3'd1, 1, 3'd7, 3'd7, 1, 1, a0, a1);

        // Single request from requester 0
        runCycle(1, 3'd1, 3'd5, 0, 3'd0, 3'd0, 1, 1, a0, a1);
        runCycle(0, 3'd0, 3'd0, 0, 3'd0, 3'd0, 1, 1, a0, a1);

        // Backpressure with requester 1 pending
        runCycle(1, 3'd2, 3'd2, 0, 3'd0, 3'd0, 0, 1, a0, a1);
        for (int i = 0; i < 3; i++) runCycle(0, 3'd0, 3'd0, 1, 3'd7, 3'd3, 0, 1, a0, a1);
        runCycle(0, 3'd0, 3'd0, 1, 3'd7, 3'd3, 1, 1, a0, a1);
        runCycle(0, 3'd0, 3'd0, 0, 3'd0, 3'd0, 1, 1, a0, a1);

        // Reset while a result is held and both requesters are valid
        runCycle(1, 3'd6, 3'd0, 0, 3'd0, 3'd0, 0, 1, a0, a1);
        runCycle(1, 3'd6, 3'd0, 1, 3'd5, 3'd4, 0, 0, a0, a1);
        runCycle(1, 3'd6, 3'd0, 1, 3'd5, 3'd4, 1, 1, a0, a1);
        runCycle(1, 3'd6, 3'd0, 1, 3'd5, 3'd4, 1, 1, a0, a1);
        runCycle(0, 3'd0, 3'd0, 0, 3'd0, 3'd0, 1, 1, a0, a1);

        // Five accepts from requester 0, one from requester 1, then reset
        for (int i = 0; i < 5; i++) runCycle(1, 3'd3, 3'd0, 0, 3'd0, 3'd0, 1, 1, a0, a1);
        runCycle(0, 3'd0, 3'd0, 1, 3'd0, 3'd1, 1, 1, a0, a1);
        runCycle(0, 3'd0, 3'd0, 0, 3'd0, 3'd0, 1, 1, a0, a1);
        runCycle(0, 3'd0, 3'd0, 0, 3'd0, 3'd0, 1, 0, a0, a1);
        runCycle(0, 3'd0, 3'd0, 0, 3'd0, 3'd0, 1, 1, a0, a1);

        // Randomized traffic; a requester holds its pair until it is taken
        p0v = 0; p1v = 0; p0a = 0; p0b = 0; p1a = 0; p1b = 0;
        a0 = 1; a1 = 1;
        for (int i = 0; i < 500; i++) begin
            if (!p0v || a0) begin
                p0v = ($urandom_range(0, 3) != 0);
                p0a = 3'($urandom_range(0, 7));
                p0b = 3'($urandom_range(0, 7));
            end
            if (!p1v || a1) begin
                p1v = ($urandom_range(0, 3) != 0);
                p1a = 3'($urandom_range(0, 7));
                p1b = 3'($urandom_range(0, 7));
            end
            rr = ($urandom_range(0, 3) != 0);
            rs = ($urandom_range(0, 99) != 0);
            runCycle(p0v, p0a, p0b, p1v, p1a, p1b, rr, rs, a0, a1);
            if (!rs) begin
                p0v = 0;
                p1v = 0;
            end
        end

        // Drain and confirm nothing was lost
        for (int i = 0; i < 5; i++) runCycle(0, 3'd0, 3'd0, 0, 3'd0, 3'd0, 1, 1, a0, a1);
        compareVal("scoreboard_leftover", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
